// File: rtl/sram22_ctrl_pkg.sv
// Shared types and sizing helpers for the sram22 port controller.
// Optional power-up zero sweep is selected with SRAM22_CTRL_INIT_EN.
package sram22_ctrl_pkg;

  localparam int unsigned CTRL_STATE_W = 1;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Width able to hold the values 0..depth inclusive.
  function automatic int unsigned rsp_cnt_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int unsigned rsp_ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Synchronous response FIFO with modulo-DEPTH pointers (any DEPTH >= 1).
// Synchronous active-low reset; storage itself is not reset.
module sram22_rsp_fifo
  import sram22_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = rsp_cnt_width(DEPTH),
  parameter int unsigned PTR_W      = rsp_ptr_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A pop frees the slot this cycle, so push-at-full is legal when popping.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram22_port_ctrl.sv
// Request/response initiator for one sram22 single-port macro with registered pins.
// Define SRAM22_CTRL_INIT_EN to zero the whole macro after every reset before opening the port.
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WMASK_WIDTH = 1,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [WMASK_WIDTH-1:0] i_req_wmask,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [DATA_WIDTH-1:0]  i_req_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_WIDTH-1:0]  o_rsp_rdata,
  output logic                   o_init_done,
  output logic                   o_sram_we,
  output logic [WMASK_WIDTH-1:0] o_sram_wmask,
  output logic [ADDR_WIDTH-1:0]  o_sram_addr,
  output logic [DATA_WIDTH-1:0]  o_sram_din,
  input  logic [DATA_WIDTH-1:0]  i_sram_dout
);

  localparam int unsigned CNT_W = rsp_cnt_width(RSP_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

`ifdef SRAM22_CTRL_INIT_EN
  localparam ctrl_state_e RESET_STATE = ST_INIT;
`else
  localparam ctrl_state_e RESET_STATE = ST_RUN;
`endif

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_next;
  logic                   w_running;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_empty;
  logic                   w_unused_fifo_full;
  logic [CNT_W-1:0]       w_fifo_count;
  logic [SUM_W-1:0]       w_inflight;
  logic                   r_rd_s1;
  logic                   r_rd_s2;
  logic                   r_sram_we;
  logic [WMASK_WIDTH-1:0] r_sram_wmask;
  logic [ADDR_WIDTH-1:0]  r_sram_addr;
  logic [DATA_WIDTH-1:0]  r_sram_din;

`ifdef SRAM22_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0]  r_init_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
`ifdef SRAM22_CTRL_INIT_EN
    if (r_state == ST_INIT && (&r_init_addr)) begin
      w_state_next = ST_RUN;
    end
`endif
  end

  assign w_running   = (r_state == ST_RUN);
  assign o_init_done = w_running;

  // Every outstanding read already owns a FIFO slot, so the T+2 push can never overflow.
  assign w_inflight  = SUM_W'(w_fifo_count) + SUM_W'(r_rd_s1) + SUM_W'(r_rd_s2);
  assign o_req_ready = w_running && (w_inflight < SUM_W'(RSP_DEPTH));
  assign w_accept    = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sram_we    <= 1'b0;
      r_sram_wmask <= '0;
      r_sram_addr  <= '0;
      r_sram_din   <= '0;
`ifdef SRAM22_CTRL_INIT_EN
    end else if (r_state == ST_INIT) begin
      r_sram_we    <= 1'b1;
      r_sram_wmask <= '1;
      r_sram_addr  <= r_init_addr;
      r_sram_din   <= '0;
`endif
    end else if (w_accept) begin
      r_sram_we    <= i_req_we;
      r_sram_wmask <= i_req_we ? i_req_wmask : '0;
      r_sram_addr  <= i_req_addr;
      r_sram_din   <= i_req_wdata;
    end else begin
      // Idle: the macro does a read whose data nobody tags.
      r_sram_we    <= 1'b0;
      r_sram_wmask <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_s1 <= 1'b0;
      r_rd_s2 <= 1'b0;
    end else begin
      r_rd_s1 <= w_accept && !i_req_we;
      r_rd_s2 <= r_rd_s1;
    end
  end

  assign o_sram_we    = r_sram_we;
  assign o_sram_wmask = r_sram_wmask;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_din   = r_sram_din;

  assign w_push      = r_rd_s2;
  assign o_rsp_valid = !w_fifo_empty;
  assign w_pop       = o_rsp_valid && i_rsp_ready;

  sram22_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (i_sram_dout),
    .i_pop   (w_pop),
    .o_rdata (o_rsp_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_unused_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
